// File: rtl/glitch_pkg.sv
// ---------------------------------------------------------------------------
// glitch_pkg
// Shared definitions for the glitch monitor: the measurement FSM state
// encoding and the default abort timeout (2 s at a 12 MHz clock).
// ---------------------------------------------------------------------------
package glitch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARMED = 3'd1,
        ST_DELAY = 3'd2,
        ST_PULSE = 3'd3,
        ST_DONE  = 3'd4,
        ST_FAIL  = 3'd5
    } state_e;

    localparam int DEFAULT_TIMEOUT = 24_000_000;

endpackage : glitch_pkg

// File: rtl/glitch_monitor_sync_edge.sv
// ---------------------------------------------------------------------------
// sync_edge
// Brings an asynchronous line into the clk domain through SYNC_STAGES flops
// (minimum 2) and detects rising/falling edges on the synchronized level.
// Both trigger and glitch paths use this block, so their latency is equal
// and cancels out of any measured interval.
//
// Ports
//   clk      in   clock
//   rst      in   synchronous active-high reset (clears all flops)
//   async_in in   asynchronous input line
//   level    out  synchronized level
//   rise     out  one-cycle pulse on a synchronized 0->1 transition
//   fall     out  one-cycle pulse on a synchronized 1->0 transition
// ---------------------------------------------------------------------------
module sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   prev_q;
    logic                   prev_d;

    assign sync_d[0] = async_in;

    genvar gi;
    generate
        for (gi = 1; gi < SYNC_STAGES; gi++) begin : g_stage
            assign sync_d[gi] = sync_q[gi-1];
        end
    endgenerate

    assign prev_d = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

endmodule : sync_edge

// File: rtl/glitch_monitor.sv
// ---------------------------------------------------------------------------
// glitch_monitor
// Measures, in clk cycles, the delay from a trigger rising edge to a glitch
// rising edge and the width of the glitch pulse. Intended to sit beside the
// glitch generator, sharing its trigger net and observing its output.
//
// Ports
//   clk           in   clock, all logic on rising edge
//   rst           in   synchronous active-high reset
//   arm           in   one-cycle request to start a measurement
//   trigger       in   asynchronous trigger line
//   glitch        in   asynchronous glitch line under test
//   busy          out  measurement in progress
//   valid         out  delay_cycles/width_cycles hold a completed result
//   error         out  last measurement aborted (timeout / glitch high early)
//   delay_cycles  out  trigger rise -> glitch rise, in cycles (saturating)
//   width_cycles  out  glitch high time, in cycles (saturating)
// ---------------------------------------------------------------------------
module glitch_monitor
    import glitch_pkg::*;
#(
    parameter int CNT_W          = 32,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT,
    parameter int SYNC_STAGES    = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             arm,
    input  logic             trigger,
    input  logic             glitch,
    output logic             busy,
    output logic             valid,
    output logic             error,
    output logic [CNT_W-1:0] delay_cycles,
    output logic [CNT_W-1:0] width_cycles
);

    localparam int             TO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    logic trig_level, trig_rise, trig_fall;
    logic glitch_level, glitch_rise, glitch_fall;

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_trigger (
        .clk      (clk),
        .rst      (rst),
        .async_in (trigger),
        .level    (trig_level),
        .rise     (trig_rise),
        .fall     (trig_fall)
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_glitch (
        .clk      (clk),
        .rst      (rst),
        .async_in (glitch),
        .level    (glitch_level),
        .rise     (glitch_rise),
        .fall     (glitch_fall)
    );

    // Trigger level and fall are not needed by the measurement.
    logic unused_trig;
    assign unused_trig = trig_level ^ trig_fall;

    state_e           state_q, state_d;
    logic             busy_q, busy_d;
    logic             valid_q, valid_d;
    logic             error_q, error_d;
    logic [CNT_W-1:0] delay_cycles_q, delay_cycles_d;
    logic [CNT_W-1:0] width_cycles_q, width_cycles_d;
    logic [CNT_W-1:0] delay_cnt_q, delay_cnt_d;
    logic [CNT_W-1:0] width_cnt_q, width_cnt_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;

    always_comb begin
        state_d        = state_q;
        busy_d         = busy_q;
        valid_d        = valid_q;
        error_d        = error_q;
        delay_cycles_d = delay_cycles_q;
        width_cycles_d = width_cycles_q;
        delay_cnt_d    = delay_cnt_q;
        width_cnt_d    = width_cnt_q;
        to_cnt_d       = to_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (arm) begin
                    state_d        = ST_ARMED;
                    busy_d         = 1'b1;
                    valid_d        = 1'b0;
                    error_d        = 1'b0;
                    delay_cycles_d = '0;
                    width_cycles_d = '0;
                    delay_cnt_d    = '0;
                    width_cnt_d    = '0;
                    to_cnt_d       = '0;
                end
            end

            ST_ARMED: begin
                if (trig_rise) begin
                    to_cnt_d = '0;
                    if (glitch_rise) begin
                        state_d        = ST_PULSE;
                        delay_cycles_d = '0;
                        width_cnt_d    = CNT_W'(1);
                    end else if (glitch_level) begin
                        // Glitch already high: the edge we would time is lost.
                        state_d = ST_FAIL;
                        error_d = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        state_d     = ST_DELAY;
                        delay_cnt_d = '0;
                    end
                end
            end

            // delay_cnt_q counts cycles after the trigger cycle minus one, so
            // the latched delay is the incremented value.
            ST_DELAY: begin
                if (to_cnt_q == TO_LAST) begin
                    state_d        = ST_FAIL;
                    error_d        = 1'b1;
                    busy_d         = 1'b0;
                    delay_cycles_d = sat_inc(delay_cnt_q);
                end else if (glitch_rise) begin
                    state_d        = ST_PULSE;
                    delay_cycles_d = sat_inc(delay_cnt_q);
                    width_cnt_d    = CNT_W'(1);
                    to_cnt_d       = to_cnt_q + TO_W'(1);
                end else begin
                    delay_cnt_d = sat_inc(delay_cnt_q);
                    to_cnt_d    = to_cnt_q + TO_W'(1);
                end
            end

            ST_PULSE: begin
                if (to_cnt_q == TO_LAST) begin
                    state_d        = ST_FAIL;
                    error_d        = 1'b1;
                    busy_d         = 1'b0;
                    width_cycles_d = width_cnt_q;
                end else if (glitch_fall) begin
                    state_d        = ST_DONE;
                    valid_d        = 1'b1;
                    busy_d         = 1'b0;
                    width_cycles_d = width_cnt_q;
                end else begin
                    if (glitch_level) begin
                        width_cnt_d = sat_inc(width_cnt_q);
                    end
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end

            ST_DONE: state_d = ST_IDLE;
            ST_FAIL: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            busy_q         <= 1'b0;
            valid_q        <= 1'b0;
            error_q        <= 1'b0;
            delay_cycles_q <= '0;
            width_cycles_q <= '0;
            delay_cnt_q    <= '0;
            width_cnt_q    <= '0;
            to_cnt_q       <= '0;
        end else begin
            state_q        <= state_d;
            busy_q         <= busy_d;
            valid_q        <= valid_d;
            error_q        <= error_d;
            delay_cycles_q <= delay_cycles_d;
            width_cycles_q <= width_cycles_d;
            delay_cnt_q    <= delay_cnt_d;
            width_cnt_q    <= width_cnt_d;
            to_cnt_q       <= to_cnt_d;
        end
    end

    assign busy         = busy_q;
    assign valid        = valid_q;
    assign error        = error_q;
    assign delay_cycles = delay_cycles_q;
    assign width_cycles = width_cycles_q;

endmodule : glitch_monitor

// File: tb/tb_glitch_monitor.sv
// ---------------------------------------------------------------------------
// tb_glitch_monitor
// Two monitors share trigger/glitch: dut_a (32-bit counters, 1000-cycle
// timeout) and dut_b (4-bit counters, 100-cycle timeout, 3 sync stages).
// Stimulus pushes expected results; per-DUT monitors pop and compare on each
// rising edge of valid or error.
// ---------------------------------------------------------------------------
module tb_glitch_monitor;

    typedef struct {
        logic        valid;
        logic        error;
        logic        check_counts;
        logic [31:0] delay;
        logic [31:0] width;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        trigger = 1'b0;
    logic        glitch = 1'b0;
    logic        arm_a = 1'b0;
    logic        arm_b = 1'b0;

    logic        busy_a, valid_a, error_a;
    logic [31:0] delay_a, width_a;
    logic        busy_b, valid_b, error_b;
    logic [3:0]  delay_b, width_b;

    int total = 0;
    int bad   = 0;

    exp_t q_a[$];
    exp_t q_b[$];

    always #5 clk = ~clk;

    glitch_monitor #(.CNT_W(32), .TIMEOUT_CYCLES(1000), .SYNC_STAGES(2)) dut_a (
        .clk          (clk),
        .rst          (rst),
        .arm          (arm_a),
        .trigger      (trigger),
        .glitch       (glitch),
        .busy         (busy_a),
        .valid        (valid_a),
        .error        (error_a),
        .delay_cycles (delay_a),
        .width_cycles (width_a)
    );

    glitch_monitor #(.CNT_W(4), .TIMEOUT_CYCLES(100), .SYNC_STAGES(3)) dut_b (
        .clk          (clk),
        .rst          (rst),
        .arm          (arm_b),
        .trigger      (trigger),
        .glitch       (glitch),
        .busy         (busy_b),
        .valid        (valid_b),
        .error        (error_b),
        .delay_cycles (delay_b),
        .width_cycles (width_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end else begin
            $display("ok   %s = %0d", name, act);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_arm(input bit which_b);
        if (which_b) arm_b = 1'b1; else arm_a = 1'b1;
        @(negedge clk);
        arm_a = 1'b0;
        arm_b = 1'b0;
    endtask

    task automatic push_a(input logic v, input logic e, input logic cc,
                          input logic [31:0] d, input logic [31:0] w);
        exp_t x;
        x.valid = v; x.error = e; x.check_counts = cc; x.delay = d; x.width = w;
        q_a.push_back(x);
    endtask

    task automatic push_b(input logic v, input logic e, input logic cc,
                          input logic [31:0] d, input logic [31:0] w);
        exp_t x;
        x.valid = v; x.error = e; x.check_counts = cc; x.delay = d; x.width = w;
        q_b.push_back(x);
    endtask

    task automatic wait_idle(input bit which_b, input string name);
        int c = 0;
        while ((which_b ? busy_b : busy_a) && c < 2000) begin
            @(negedge clk);
            c++;
        end
        chk(name, 32'(which_b ? busy_b : busy_a), 32'd0);
    endtask

    // Scoreboard monitor for dut_a.
    initial begin
        logic pv = 1'b0;
        logic pe = 1'b0;
        exp_t x;
        forever begin
            @(negedge clk);
            if ((valid_a && !pv) || (error_a && !pe)) begin
                if (q_a.size() == 0) begin
                    chk("a_unexpected_event", 32'd1, 32'd0);
                end else begin
                    x = q_a.pop_front();
                    chk("a_valid", 32'(valid_a), 32'(x.valid));
                    chk("a_error", 32'(error_a), 32'(x.error));
                    chk("a_busy_at_end", 32'(busy_a), 32'd0);
                    if (x.check_counts) begin
                        chk("a_delay", delay_a, x.delay);
                        chk("a_width", width_a, x.width);
                    end
                end
            end
            pv = valid_a;
            pe = error_a;
        end
    end

    // Scoreboard monitor for dut_b.
    initial begin
        logic pv = 1'b0;
        logic pe = 1'b0;
        exp_t x;
        forever begin
            @(negedge clk);
            if ((valid_b && !pv) || (error_b && !pe)) begin
                if (q_b.size() == 0) begin
                    chk("b_unexpected_event", 32'd1, 32'd0);
                end else begin
                    x = q_b.pop_front();
                    chk("b_valid", 32'(valid_b), 32'(x.valid));
                    chk("b_error", 32'(error_b), 32'(x.error));
                    chk("b_busy_at_end", 32'(busy_b), 32'd0);
                    if (x.check_counts) begin
                        chk("b_delay", {28'd0, delay_b}, x.delay);
                        chk("b_width", {28'd0, width_b}, x.width);
                    end
                end
            end
            pv = valid_b;
            pe = error_b;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;

        // Reset state
        tick(3);
        rst = 1'b0;
        tick(1);
        chk("rst_busy_a",  32'(busy_a),  32'd0);
        chk("rst_valid_a", 32'(valid_a), 32'd0);
        chk("rst_error_a", 32'(error_a), 32'd0);
        chk("rst_delay_a", delay_a,      32'd0);
        chk("rst_width_a", width_a,      32'd0);
        chk("rst_busy_b",  32'(busy_b),  32'd0);

        // Delay 100 / width 12, with an extra trigger rise and an arm
        // during DELAY that must both be ignored.
        pulse_arm(1'b0);
        chk("busy_after_arm", 32'(busy_a), 32'd1);
        push_a(1'b1, 1'b0, 1'b1, 32'd100, 32'd12);
        trigger = 1'b1; tick(20);
        trigger = 1'b0; tick(20);
        trigger = 1'b1; tick(10);
        pulse_arm(1'b0);
        tick(49);
        glitch = 1'b1; tick(12);
        glitch = 1'b0;
        wait_idle(1'b0, "t1_idle");
        trigger = 1'b0; tick(5);
        chk("t1_valid_held", 32'(valid_a), 32'd1);

        // Trigger and glitch rise together, glitch high 5 cycles.
        pulse_arm(1'b0);
        chk("t2_valid_cleared", 32'(valid_a), 32'd0);
        push_a(1'b1, 1'b0, 1'b1, 32'd0, 32'd5);
        trigger = 1'b1; glitch = 1'b1; tick(5);
        glitch = 1'b0;
        wait_idle(1'b0, "t2_idle");
        trigger = 1'b0; tick(5);

        // Timeout with no glitch.
        pulse_arm(1'b0);
        push_a(1'b0, 1'b1, 1'b0, 32'd0, 32'd0);
        trigger = 1'b1;
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!error_a && c < 1100);
        chk("t3_timeout_in_window", 32'(c >= 1000 && c <= 1004), 32'd1);
        tick(2);
        chk("t3_valid", 32'(valid_a), 32'd0);
        trigger = 1'b0; tick(5);

        // Glitch already high when trigger rises.
        glitch = 1'b1; tick(5);
        pulse_arm(1'b0);
        push_a(1'b0, 1'b1, 1'b1, 32'd0, 32'd0);
        trigger = 1'b1;
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!error_a && c < 20);
        chk("t4_error_latency", 32'(c >= 2 && c <= 4), 32'd1);
        wait_idle(1'b0, "t4_idle");
        glitch = 1'b0; trigger = 1'b0; tick(5);

        // Saturation: 4-bit counters, glitch 40 cycles after trigger.
        pulse_arm(1'b1);
        push_b(1'b1, 1'b0, 1'b1, 32'd15, 32'd3);
        trigger = 1'b1; tick(40);
        glitch = 1'b1; tick(3);
        glitch = 1'b0;
        wait_idle(1'b1, "t5_idle");
        trigger = 1'b0; tick(5);

        // Reset during PULSE, then a normal measurement.
        pulse_arm(1'b0);
        trigger = 1'b1; tick(10);
        glitch = 1'b1; tick(5);
        rst = 1'b1; tick(1);
        rst = 1'b0;
        chk("t6_rst_busy",  32'(busy_a),  32'd0);
        chk("t6_rst_valid", 32'(valid_a), 32'd0);
        chk("t6_rst_error", 32'(error_a), 32'd0);
        chk("t6_rst_delay", delay_a,      32'd0);
        chk("t6_rst_width", width_a,      32'd0);
        glitch = 1'b0; trigger = 1'b0; tick(5);
        pulse_arm(1'b0);
        push_a(1'b1, 1'b0, 1'b1, 32'd30, 32'd7);
        trigger = 1'b1; tick(30);
        glitch = 1'b1; tick(7);
        glitch = 1'b0;
        wait_idle(1'b0, "t6_idle");
        trigger = 1'b0; tick(10);

        chk("sb_a_drained", 32'(q_a.size()), 32'd0);
        chk("sb_b_drained", 32'(q_b.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_glitch_monitor

// File: doc/glitch_monitor.md
GLITCH_MONITOR -- requirements
Module: glitch_monitor

Interface
REQ-001 SHALL have parameter CNT_W, default 32: width of the delay and width counters.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 24_000_000: cycles from trigger edge to abort (2 s at 12 MHz).
REQ-003 SHALL have parameter SYNC_STAGES, default 2, minimum 2: synchronizer depth on trigger and glitch.
REQ-004 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port arm, input, 1: one-cycle request to start a measurement.
REQ-007 SHALL have port trigger, input, 1: asynchronous trigger line, the same net that drives the generator.
REQ-008 SHALL have port glitch, input, 1: asynchronous glitch line under test.
REQ-009 SHALL have port busy, output, 1: high from arm acceptance until the measurement completes.
REQ-010 SHALL have port valid, output, 1: high while delay_cycles and width_cycles hold a completed measurement.
REQ-011 SHALL have port error, output, 1: high after an aborted measurement (timeout, or glitch already high at trigger).
REQ-012 SHALL have port delay_cycles, output, CNT_W: cycles from trigger rise to glitch rise.
REQ-013 SHALL have port width_cycles, output, CNT_W: cycles glitch was high.

Function
REQ-014 trigger and glitch SHALL each pass through SYNC_STAGES flops and then a rising/falling edge detector, with identical latency on both paths.
REQ-015 States SHALL be IDLE, ARMED, DELAY, PULSE, DONE and FAIL.
REQ-016 IDLE: arm moves to ARMED, clears valid, error, delay_cycles and width_cycles, and raises busy on the next cycle.
REQ-017 ARMED: a synchronized trigger rise goes to DELAY with delay count 0; if synchronized glitch is high in that same cycle without a glitch rise, go to FAIL.
REQ-018 A trigger rise and a glitch rise in the same cycle SHALL go directly to PULSE with delay_cycles = 0 and width count 1.
REQ-019 DELAY: delay count increments each cycle; a glitch rise latches the count into delay_cycles, sets width count to 1, and goes to PULSE.
REQ-020 PULSE: width count increments each cycle glitch stays high; a glitch fall latches width_cycles and goes to DONE.
REQ-021 DONE: valid is asserted for one cycle, then the block returns to IDLE with valid held high and busy low.
REQ-022 FAIL: error is asserted, busy drops, and the block returns to IDLE on the next cycle; results keep their partial counts.
REQ-023 A timeout counter SHALL start at the trigger rise and run through DELAY and PULSE; reaching TIMEOUT_CYCLES goes to FAIL.
REQ-024 Delay and width counters SHALL saturate at all-ones and never wrap.
REQ-025 arm while busy SHALL be ignored; extra trigger rises in DELAY or PULSE SHALL be ignored.
REQ-026 Outputs SHALL be registered; valid/error rise at most one cycle after the qualifying edge.
REQ-027 Measured values SHALL be referenced to clk; the synchronizer latency is common to both paths and cancels out.

Reset
REQ-028 rst SHALL force state IDLE; busy, valid and error to 0; all counters, delay_cycles and width_cycles to 0; synchronizer flops to 0.
REQ-029 rst asserted mid-measurement SHALL abandon it with no valid and no error pulse.
REQ-030 rst SHALL override arm in the same cycle.

Structure
REQ-031 The state enum and a default-TIMEOUT constant SHALL live in shared package glitch_pkg.
REQ-032 One sub-module, sync_edge (synchronizer plus rise/fall detect, parameter SYNC_STAGES), SHALL be instantiated twice.
REQ-033 The block SHALL be instantiable beside the generator in the top level, sharing trigger and observing glitch for self-test.

Verification
REQ-034 Arm, trigger rise, glitch rises 100 cycles later and is high 12 cycles -> valid=1, delay_cycles=100, width_cycles=12, error=0.
REQ-035 Trigger and glitch rise in the same cycle, glitch high 5 cycles -> delay_cycles=0, width_cycles=5, valid=1.
REQ-036 TIMEOUT_CYCLES=1000, trigger, no glitch -> error=1 at cycle 1000 (+1), valid=0, busy=0.
REQ-037 Glitch held high before trigger -> error=1 one cycle after the trigger edge, delay_cycles=0.
REQ-038 CNT_W=4, TIMEOUT_CYCLES=100, glitch at 40 cycles -> delay_cycles=15 (saturated), valid=1.
REQ-039 rst pulsed during PULSE -> all outputs 0; then a following arm/trigger/glitch measures normally.
